ysyx22041405_lsu: RTL and testbench

YSYX22041405_LSU -- requirements
Module: ysyx22041405_LSU

---
 rtl/ysyx22041405_lsu.sv | 156 +++++++++++++++
 tb/tb_ysyx22041405_lsu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx22041405_lsu.sv
// Load/store unit between the EX and WB stages. It runs one instruction at a time through
// IDLE -> (REQ -> WAIT) -> DONE, with byte-lane store steering and sign/zero-extended loads.
module ysyx22041405_lsu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   output logic             ls_ready,
   input  logic [63:0]      ex_if_mes,
   input  logic [WIDTH-1:0] ex_alu_result,
   input  logic [WIDTH-1:0] ex_store_data,
   input  logic             ex_ld_en,
   input  logic             ex_st_en,
   input  logic [2:0]       ex_mem_op,
   input  logic             ex_rf_we,
   input  logic [4:0]       ex_rf_waddr,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_wen,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_rsp_valid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [63:0]      wb_if_mes,
   output logic [WIDTH-1:0] wb_result,
   output logic             wb_rf_we,
   output logic [4:0]       wb_rf_waddr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t state, next_state;

   logic [63:0]      if_mes_q;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] sdata_q;
   logic             ld_q;
   logic             st_q;
   logic [2:0]       op_q;
   logic             rf_we_q;
   logic [4:0]       rf_waddr_q;
   logic [WIDTH-1:0] result_q;

   logic             accept;
   logic             mem_done;
   logic             is_store;
   logic [1:0]       off;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] lane_wdata;
   logic [3:0]       lane_wstrb;

   assign accept   = (state == IDLE) && ex_valid;
   // A response landing in the same cycle the request is accepted skips WAIT entirely.
   assign mem_done = ((state == REQ) && mem_req_ready && mem_rsp_valid) ||
                     ((state == WAIT) && mem_rsp_valid);
   assign is_store = st_q && !ld_q;
   assign off      = addr_q[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (ex_valid) next_state = (ex_ld_en || ex_st_en) ? REQ : DONE;
         REQ:  if (mem_req_ready) next_state = mem_rsp_valid ? DONE : WAIT;
         WAIT: if (mem_rsp_valid) next_state = DONE;
         DONE: if (wb_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Stores keep the address as their result; loads overwrite it when the data returns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_mes_q   <= '0;
         addr_q     <= '0;
         sdata_q    <= '0;
         ld_q       <= 1'b0;
         st_q       <= 1'b0;
         op_q       <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         result_q   <= '0;
      end else begin
         if (accept) begin
            if_mes_q   <= ex_if_mes;
            addr_q     <= ex_alu_result;
            sdata_q    <= ex_store_data;
            ld_q       <= ex_ld_en;
            st_q       <= ex_st_en;
            op_q       <= ex_mem_op;
            rf_we_q    <= ex_rf_we;
            rf_waddr_q <= ex_rf_waddr;
            result_q   <= ex_alu_result;
         end
         if (mem_done && ld_q) result_q <= load_data;
      end
   end

   assign rd_byte = mem_rdata[{off, 3'b000} +: 8];
   assign rd_half = mem_rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      load_data = mem_rdata;
      case (op_q)
         3'b000:  load_data = {{(WIDTH-8){rd_byte[7]}}, rd_byte};
         3'b001:  load_data = {{(WIDTH-16){rd_half[15]}}, rd_half};
         3'b100:  load_data = {{(WIDTH-8){1'b0}}, rd_byte};
         3'b101:  load_data = {{(WIDTH-16){1'b0}}, rd_half};
         default: load_data = mem_rdata;
      endcase
   end

   // Store data is replicated across every lane so the strobe alone picks the target bytes.
   always_comb begin
      lane_wdata = sdata_q;
      lane_wstrb = 4'b1111;
      case (op_q[1:0])
         2'b00: begin
            lane_wdata = {4{sdata_q[7:0]}};
            lane_wstrb = 4'b0001 << off;
         end
         2'b01: begin
            lane_wdata = {2{sdata_q[15:0]}};
            lane_wstrb = 4'b0011 << {off[1], 1'b0};
         end
         default: begin
            lane_wdata = sdata_q;
            lane_wstrb = 4'b1111;
         end
      endcase
   end

   assign ls_ready      = (state == IDLE);
   assign mem_req_valid = (state == REQ);
   assign mem_addr      = (state == REQ) ? {addr_q[WIDTH-1:2], 2'b00} : '0;
   assign mem_wen       = (state == REQ) && is_store;
   assign mem_wdata     = ((state == REQ) && is_store) ? lane_wdata : '0;
   assign mem_wstrb     = ((state == REQ) && is_store) ? lane_wstrb : 4'b0000;

   assign wb_valid    = (state == DONE);
   assign wb_if_mes   = if_mes_q;
   assign wb_result   = result_q;
   assign wb_rf_we    = rf_we_q;
   assign wb_rf_waddr = rf_waddr_q;

endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// Directed self-checking bench for ysyx22041405_lsu: ALU pass-through, loads, stores,
// stalls on both handshakes and a reset abandoning an in-flight load.
module tb_ysyx22041405_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ls_ready;
   logic [63:0] ex_if_mes;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic        ex_ld_en;
   logic        ex_st_en;
   logic [2:0]  ex_mem_op;
   logic        ex_rf_we;
   logic [4:0]  ex_rf_waddr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic        wb_ready;
   logic [63:0] wb_if_mes;
   logic [31:0] wb_result;
   logic        wb_rf_we;
   logic [4:0]  wb_rf_waddr;

   int checks   = 0;
   int failures = 0;

   ysyx22041405_lsu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ls_ready(ls_ready), .ex_if_mes(ex_if_mes),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_ld_en(ex_ld_en), .ex_st_en(ex_st_en), .ex_mem_op(ex_mem_op),
      .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_if_mes(wb_if_mes),
      .wb_result(wb_result), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] op,
                                input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [4:0] waddr);
      ex_valid      = 1'b1;
      ex_ld_en      = ld;
      ex_st_en      = st;
      ex_mem_op     = op;
      ex_alu_result = alu;
      ex_store_data = sdata;
      ex_rf_we      = ld || !st;
      ex_rf_waddr   = waddr;
      ex_if_mes     = {32'h8000_0100, alu ^ 32'h0000_0013};
      tick();
      ex_valid      = 1'b0;
   endtask

   initial begin
      rst = 1'b0; ex_valid = 1'b0; ex_if_mes = '0; ex_alu_result = '0; ex_store_data = '0;
      ex_ld_en = 1'b0; ex_st_en = 1'b0; ex_mem_op = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; wb_ready = 1'b1;
      #3;
      checkOutput("rst_ls_ready", 64'(ls_ready), 64'd1);
      checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
      checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
      checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst_wstrb", 64'(mem_wstrb), 64'd0);
      checkOutput("rst_wb_result", 64'(wb_result), 64'd0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // addi: one cycle to DONE, never touches memory
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
      checkOutput("alu_wb_valid", 64'(wb_valid), 64'd1);
      checkOutput("alu_wb_result", 64'(wb_result), 64'h1234);
      checkOutput("alu_req_valid", 64'(mem_req_valid), 64'd0);
      checkOutput("alu_waddr", 64'(wb_rf_waddr), 64'd5);
      checkOutput("alu_if_mes", wb_if_mes, {32'h8000_0100, 32'h0000_1227});
      checkOutput("alu_ls_ready", 64'(ls_ready), 64'd0);
      tick();
      checkOutput("alu_back_idle", 64'(ls_ready), 64'd1);

      // lb 0x80000003
      applyStimulus(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd6);
      checkOutput("lb_req_valid", 64'(mem_req_valid), 64'd1);
      checkOutput("lb_addr", 64'(mem_addr), 64'h8000_0000);
      checkOutput("lb_wen", 64'(mem_wen), 64'd0);
      checkOutput("lb_wstrb", 64'(mem_wstrb), 64'd0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      checkOutput("lb_wait_req", 64'(mem_req_valid), 64'd0);
      checkOutput("lb_wait_wb", 64'(wb_valid), 64'd0);
      mem_rsp_valid = 1'b1; mem_rdata = 32'h80FF_0000;
      tick();
      mem_rsp_valid = 1'b0;
      checkOutput("lb_wb_valid", 64'(wb_valid), 64'd1);
      checkOutput("lb_result", 64'(wb_result), 64'hFFFF_FF80);
      tick();

      // lbu 0x80000003
      applyStimulus(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd7);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h80FF_0000;
      tick();
      mem_rsp_valid = 1'b0;
      checkOutput("lbu_result", 64'(wb_result), 64'h0000_0080);
      tick();

      // sh 0xABCD1234 at 0x102, ready held off 3 cycles, then WB stalled 5 cycles
      applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 5'd0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_req_ready = 1'b1;
         checkOutput($sformatf("sh_req_valid_%0d", i), 64'(mem_req_valid), 64'd1);
         checkOutput($sformatf("sh_addr_%0d", i), 64'(mem_addr), 64'h0000_0100);
         checkOutput($sformatf("sh_wdata_%0d", i), 64'(mem_wdata), 64'h1234_1234);
         checkOutput($sformatf("sh_wstrb_%0d", i), 64'(mem_wstrb), 64'b1100);
         checkOutput($sformatf("sh_wen_%0d", i), 64'(mem_wen), 64'd1);
         tick();
      end
      mem_req_ready = 1'b0;
      checkOutput("sh_wait", 64'(mem_req_valid), 64'd0);
      wb_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall_wb_valid_%0d", i), 64'(wb_valid), 64'd1);
         checkOutput($sformatf("stall_result_%0d", i), 64'(wb_result), 64'h0000_0102);
         checkOutput($sformatf("stall_rf_we_%0d", i), 64'(wb_rf_we), 64'd0);
         checkOutput($sformatf("stall_ls_ready_%0d", i), 64'(ls_ready), 64'd0);
         tick();
      end
      wb_ready = 1'b1;
      tick();
      checkOutput("stall_released", 64'(wb_valid), 64'd0);

      // lw with ready and response in the same cycle goes straight to DONE
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9);
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      checkOutput("lw_fast_wb_valid", 64'(wb_valid), 64'd1);
      checkOutput("lw_fast_result", 64'(wb_result), 64'hDEAD_BEEF);
      tick();

      // both ld and st set at a misaligned halfword: behaves as lh from the low half
      applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_0301, 32'h5555_5555, 5'd10);
      checkOutput("ldst_wen", 64'(mem_wen), 64'd0);
      checkOutput("ldst_wstrb", 64'(mem_wstrb), 64'd0);
      checkOutput("ldst_addr", 64'(mem_addr), 64'h0000_0300);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_8001;
      tick();
      mem_rsp_valid = 1'b0;
      checkOutput("lh_result", 64'(wb_result), 64'hFFFF_8001);
      tick();

      // reset during WAIT, then a stray response
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd11);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("rst_mid_ls_ready", 64'(ls_ready), 64'd1);
      checkOutput("rst_mid_wb_valid", 64'(wb_valid), 64'd0);
      checkOutput("rst_mid_wb_result", 64'(wb_result), 64'd0);
      tick();
      rst = 1'b1;
      mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_rsp_valid = 1'b0;
      checkOutput("late_rsp_wb_valid", 64'(wb_valid), 64'd0);
      checkOutput("late_rsp_ls_ready", 64'(ls_ready), 64'd1);
      checkOutput("late_rsp_result", 64'(wb_result), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
